// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// XLEN/ILEN are package-wide so the fetch entry type has a single definition
// for the top, its queues and the interface.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Fetch targets are word aligned; the low address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Control, instruction-memory and ID-handshake bundle of the fetch unit.
//   master: fetch-unit view (drives imem_req/imem_addr and the ID head)
//   slave : environment view (memory, ID stage and redirect source)
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
();

  logic            enable;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_instr;

  modport master (
    input  enable, redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_pc, id_instr
  );

  modport slave (
    output enable, redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_pc, id_instr
  );

endinterface

// File: rtl/if_fetch_unit_fetch_queue.sv
// Synchronous FIFO used for the instruction queue and the PC tag FIFO.
//   clk, reset   : clock, asynchronous active-high reset
//   flush_i      : drop all entries; a push in the same cycle survives the flush
//   push_i/pop_i : write tail / release head (push allowed when full if popping)
//   head_o       : current head entry
//   empty_o/full_o/count_o : occupancy
module if_fetch_unit_fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  entry_t                       push_data_i,
  input  logic                         pop_i,
  output entry_t                       head_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              do_push, do_pop, we;
  logic [PtrW-1:0]   wa;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign we      = flush_i ? push_i : do_push;
  assign wa      = flush_i ? '0 : wr_ptr_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= push_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= push_i ? ptr_inc('0) : '0;
      cnt_q    <= CntW'(push_i);
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: holds the fetch PC, issues pipelined imem
// requests (req/gnt, in-order rvalid), tags responses with their PC and
// buffers them for ID. Redirects flush the queue and drop stale responses.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : control, imem and ID signals (master view)
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     FQ_DEPTH  = 4,
  parameter int unsigned     MAX_OUTST = 4
) (
  input  logic           clk,
  input  logic           reset,
  if_fetch_unit_if.master bus
);

  localparam int unsigned OutW  = $clog2(MAX_OUTST + 1);
  localparam int unsigned FqCnW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [OutW-1:0]  outst_q, outst_d;   // all granted, unanswered requests
  logic [OutW-1:0]  drop_q, drop_d;     // oldest in-flight responses to discard
  logic [XLEN-1:0]  redirect_tgt;
  logic [31:0]      credit_used;
  logic             grant, live_rsp, fq_pop;

  fetch_entry_t     fq_head, fq_push_data;
  logic             fq_empty, fq_full;
  logic [FqCnW-1:0] fq_count;
  logic [XLEN-1:0]  tag_head;
  logic             tag_empty, tag_full;
  logic [OutW-1:0]  tag_count;

  assign redirect_tgt = align_pc(bus.redirect_pc);

  // Queue slots already promised: buffered entries plus live responses in flight.
  assign credit_used  = 32'(fq_count) + 32'(outst_q) - 32'(drop_q);
  assign bus.imem_req = !reset && bus.enable && (credit_used < 32'(FQ_DEPTH)) &&
                        (32'(outst_q) < 32'(MAX_OUTST));
  assign bus.imem_addr = bus.redirect_valid ? redirect_tgt : fetch_pc_q;
  assign grant         = bus.imem_req && bus.imem_gnt;

  // A response in the redirect cycle belongs to the old stream.
  assign live_rsp = bus.imem_rvalid && !bus.redirect_valid && (drop_q == '0);

  assign bus.id_valid = !fq_empty && !bus.redirect_valid;
  assign bus.id_pc    = fq_empty ? '0 : fq_head.pc;
  assign bus.id_instr = fq_empty ? '0 : fq_head.instr;
  assign fq_pop       = bus.id_valid && bus.id_ready;

  assign fq_push_data = '{pc: tag_head, instr: bus.imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (grant)                   fetch_pc_d = bus.imem_addr + XLEN'(INSTR_BYTES);
    else if (bus.redirect_valid) fetch_pc_d = redirect_tgt;

    outst_d = outst_q + OutW'(grant) - OutW'(bus.imem_rvalid);

    drop_d = drop_q;
    if (bus.redirect_valid)                  drop_d = outst_q - OutW'(bus.imem_rvalid);
    else if (bus.imem_rvalid && drop_q != '0) drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // PCs of live requests; the redirect-cycle grant is pushed past the flush.
  if_fetch_unit_fetch_queue #(
    .DEPTH   (MAX_OUTST),
    .entry_t (logic [XLEN-1:0])
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.redirect_valid),
    .push_i      (grant),
    .push_data_i (bus.imem_addr),
    .pop_i       (live_rsp),
    .head_o      (tag_head),
    .empty_o     (tag_empty),
    .full_o      (tag_full),
    .count_o     (tag_count)
  );

  if_fetch_unit_fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fetch_queue (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.redirect_valid),
    .push_i      (live_rsp),
    .push_data_i (fq_push_data),
    .pop_i       (fq_pop),
    .head_o      (fq_head),
    .empty_o     (fq_empty),
    .full_o      (fq_full),
    .count_o     (fq_count)
  );

  outst_under_a: assert property (@(posedge clk) disable iff (reset)
    bus.imem_rvalid |-> outst_q != '0);
  outst_over_a:  assert property (@(posedge clk) disable iff (reset)
    grant |-> (32'(outst_q) < 32'(MAX_OUTST) && !tag_full));
  tag_sync_a:    assert property (@(posedge clk) disable iff (reset)
    tag_count == outst_q - drop_q);
  live_tag_a:    assert property (@(posedge clk) disable iff (reset)
    live_rsp |-> (!tag_empty && (!fq_full || fq_pop)));

endmodule
